// File: rtl/timer_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_irq_pkg
// Brief    : Shared types and constants for the timer interrupt scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package timer_irq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        ASSERT = 2'd2,
        GAP    = 2'd3
    } sched_state_t;

    localparam int          MISS_CNT_W      = 16;
    localparam logic [31:0] DEF_ACK_TIMEOUT = 32'd10000;
    localparam logic [31:0] DEF_HOLDOFF     = 32'd4;

endpackage
`default_nettype wire

// File: rtl/timer_irq_arb.sv
`default_nettype none
// ============================================================================
// Module   : timer_irq_arb
// Brief    : Combinational picker: first set request at or after start, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module timer_irq_arb #(
    parameter int NUM_SRC = 15,
    parameter int VEC_W   = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [VEC_W-1:0]   start,
    output logic [VEC_W-1:0]   grant,
    output logic               grant_vld
);

    // Scanning from the far end means the nearest hit to start is assigned last.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            int                 idx;
            logic [NUM_SRC-1:0] w_shifted;
            idx = int'(start) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            w_shifted = req >> idx;
            if (w_shifted[0]) begin
                grant     = VEC_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_irq_sched.sv
`default_nettype none
// ============================================================================
// Module   : timer_irq_sched
// Brief    : Latches source edges, arbitrates, drives MicroBlaze irq with ack
//            timeout. Define TIMER_IRQ_RR_EN for round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module timer_irq_sched
    import timer_irq_pkg::*;
#(
    parameter int          NUM_SRC     = 15,
    parameter int          VEC_W       = 4,
    parameter logic [31:0] ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter logic [31:0] HOLDOFF     = DEF_HOLDOFF
) (
    input  logic                  clk_100,
    input  logic                  rst_100,
    input  logic [NUM_SRC-1:0]    irq_src,
    input  logic [NUM_SRC-1:0]    irq_mask,
    input  logic                  irq_ack,
    output logic                  irq_out,
    output logic [VEC_W-1:0]      irq_vec,
    output logic [NUM_SRC-1:0]    pend_o,
    output logic [MISS_CNT_W-1:0] miss_cnt,
    output logic                  timeout_o
);

    sched_state_t            r_state;
    sched_state_t            w_state_next;
    logic [NUM_SRC-1:0]      r_src_d;
    logic [NUM_SRC-1:0]      r_pend;
    logic [MISS_CNT_W-1:0]   r_miss_cnt;
    logic                    r_irq_out;
    logic [VEC_W-1:0]        r_irq_vec;
    logic                    r_timeout;
    logic [31:0]             r_wait_cnt;
    logic [31:0]             r_gap_cnt;

    logic [NUM_SRC-1:0]      w_edge;
    logic [NUM_SRC-1:0]      w_req_unmasked;
    logic [NUM_SRC-1:0]      w_arb_req;
    logic [NUM_SRC-1:0]      w_clr;
    logic [NUM_SRC-1:0]      w_lost;
    logic [VEC_W-1:0]        w_start;
    logic [VEC_W-1:0]        w_grant;
    logic                    w_grant_vld;
    logic                    w_ack_done;
    logic                    w_timeout_hit;
    logic [MISS_CNT_W:0]     w_miss_sum;
    logic [MISS_CNT_W-1:0]   w_miss_next;

    assign w_edge         = irq_src & ~r_src_d;
    assign w_req_unmasked = r_pend & ~irq_mask;
    // A mask change during ARB must not strand the service: fall back to raw pend.
    assign w_arb_req      = (|w_req_unmasked) ? w_req_unmasked : r_pend;

`ifdef TIMER_IRQ_RR_EN
    logic [VEC_W-1:0] r_last_winner;

    assign w_start = (r_last_winner == VEC_W'(NUM_SRC - 1)) ? '0 : r_last_winner + 1'b1;

    always_ff @(posedge clk_100 or posedge rst_100) begin
        if (rst_100) begin
            r_last_winner <= VEC_W'(NUM_SRC - 1);
        end else if (r_state == ARB && w_grant_vld) begin
            r_last_winner <= w_grant;
        end
    end
`else
    assign w_start = '0;
`endif

    timer_irq_arb #(
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W)
    ) u_arb (
        .req       (w_arb_req),
        .start     (w_start),
        .grant     (w_grant),
        .grant_vld (w_grant_vld)
    );

    always_comb begin
        w_state_next  = r_state;
        w_ack_done    = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req_unmasked) begin
                    w_state_next = ARB;
                end
            end
            ARB: begin
                w_state_next = ASSERT;
            end
            ASSERT: begin
                if (irq_ack) begin
                    w_ack_done   = 1'b1;
                    w_state_next = GAP;
                end else if (r_wait_cnt == ACK_TIMEOUT - 32'd1) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = GAP;
                end
            end
            GAP: begin
                if (r_gap_cnt == HOLDOFF - 32'd1) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_clr[i] = (w_ack_done || w_timeout_hit) && (r_irq_vec == VEC_W'(i));
        end
    end

    // A fresh edge on a bit being cleared re-arms it and is not counted as lost.
    assign w_lost = w_edge & r_pend & ~w_clr;

    always_comb begin
        w_miss_sum = {1'b0, r_miss_cnt};
        for (int i = 0; i < NUM_SRC; i++) begin
            w_miss_sum = w_miss_sum + (MISS_CNT_W + 1)'(w_lost[i]);
        end
        w_miss_next = w_miss_sum[MISS_CNT_W] ? '1 : w_miss_sum[MISS_CNT_W-1:0];
    end

    always_ff @(posedge clk_100 or posedge rst_100) begin
        if (rst_100) begin
            r_state    <= IDLE;
            r_src_d    <= '0;
            r_pend     <= '0;
            r_miss_cnt <= '0;
            r_irq_out  <= 1'b0;
            r_irq_vec  <= '0;
            r_timeout  <= 1'b0;
            r_wait_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_src_d    <= irq_src;
            r_pend     <= (r_pend & ~w_clr) | w_edge;
            r_miss_cnt <= w_miss_next;
            r_irq_out  <= (w_state_next == ASSERT);
            if (r_state == ARB && w_grant_vld) begin
                r_irq_vec <= w_grant;
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
            r_wait_cnt <= (r_state == ASSERT) ? r_wait_cnt + 32'd1 : 32'd0;
            r_gap_cnt  <= (r_state == GAP) ? r_gap_cnt + 32'd1 : 32'd0;
        end
    end

    assign irq_out   = r_irq_out;
    assign irq_vec   = r_irq_vec;
    assign pend_o    = r_pend;
    assign miss_cnt  = r_miss_cnt;
    assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_timer_irq_sched
// Brief    : Directed and randomized bench against a timeline model of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_irq_sched;

    localparam int NUM_SRC = 15;
    localparam int VEC_W   = 4;
    localparam int ACK_TO  = 20;
    localparam int HOLD    = 4;

    localparam int M_FREE = 0;
    localparam int M_PICK = 1;
    localparam int M_SERV = 2;
    localparam int M_COOL = 3;

    logic               clk_100  = 1'b0;
    logic               rst_100  = 1'b1;
    logic [NUM_SRC-1:0] irq_src  = '0;
    logic [NUM_SRC-1:0] irq_mask = '0;
    logic               irq_ack  = 1'b0;
    logic               irq_out;
    logic [VEC_W-1:0]   irq_vec;
    logic [NUM_SRC-1:0] pend_o;
    logic [15:0]        miss_cnt;
    logic               timeout_o;

    timer_irq_sched #(
        .NUM_SRC     (NUM_SRC),
        .VEC_W       (VEC_W),
        .ACK_TIMEOUT (32'(ACK_TO)),
        .HOLDOFF     (32'(HOLD))
    ) dut (
        .clk_100   (clk_100),
        .rst_100   (rst_100),
        .irq_src   (irq_src),
        .irq_mask  (irq_mask),
        .irq_ack   (irq_ack),
        .irq_out   (irq_out),
        .irq_vec   (irq_vec),
        .pend_o    (pend_o),
        .miss_cnt  (miss_cnt),
        .timeout_o (timeout_o)
    );

    always #5 clk_100 = ~clk_100;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: service timeline derived from the externally visible rules.
    logic [NUM_SRC-1:0] m_pend = '0;
    logic [NUM_SRC-1:0] m_prev = '0;
    int                 m_miss = 0;
    logic               m_to   = 1'b0;
    logic               m_out  = 1'b0;
    int                 m_vec  = 0;
    int                 m_mode = M_FREE;
    int                 m_held = 0;
    int                 m_cool = 0;
    int                 m_last = NUM_SRC - 1;

    function automatic int pick(input logic [NUM_SRC-1:0] req, input int start);
        for (int k = 0; k < NUM_SRC; k++) begin
            int idx;
            idx = (start + k) % NUM_SRC;
            if (req[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_miss = 0; m_to = 1'b0; m_out = 1'b0;
        m_vec = 0; m_mode = M_FREE; m_held = 0; m_cool = 0; m_last = NUM_SRC - 1;
    endtask

    task automatic model_step();
        logic [NUM_SRC-1:0] edg;
        logic [NUM_SRC-1:0] clr;
        logic [NUM_SRC-1:0] req;
        int                 st;
        edg = irq_src & ~m_prev;
        clr = '0;
        case (m_mode)
            M_FREE: if ((m_pend & ~irq_mask) != '0) m_mode = M_PICK;
            M_PICK: begin
                req = m_pend & ~irq_mask;
                if (req == '0) req = m_pend;
                st = 0;
`ifdef TIMER_IRQ_RR_EN
                st = (m_last + 1) % NUM_SRC;
`endif
                m_vec  = pick(req, st);
                m_last = m_vec;
                m_out  = 1'b1;
                m_held = 0;
                m_mode = M_SERV;
            end
            M_SERV: begin
                m_held++;
                if (irq_ack || m_held == ACK_TO) begin
                    clr[m_vec] = 1'b1;
                    if (!irq_ack) m_to = 1'b1;
                    m_out  = 1'b0;
                    m_cool = HOLD;
                    m_mode = M_COOL;
                end
            end
            default: begin
                m_cool--;
                if (m_cool == 0) m_mode = M_FREE;
            end
        endcase
        for (int i = 0; i < NUM_SRC; i++) begin
            if (edg[i] && m_pend[i] && !clr[i] && m_miss < 65535) m_miss++;
        end
        m_pend = (m_pend & ~clr) | edg;
        m_prev = irq_src;
    endtask

    always @(posedge clk_100 or posedge rst_100) begin
        if (rst_100) model_reset();
        else         model_step();
        #1;
        check("cyc_irq_out", 32'(irq_out), 32'(m_out));
        check("cyc_irq_vec", 32'(irq_vec), 32'(m_vec));
        check("cyc_pend", 32'(pend_o), 32'(m_pend));
        check("cyc_miss", 32'(miss_cnt), 32'(m_miss));
        check("cyc_timeout", 32'(timeout_o), 32'(m_to));
    end

    // Counts negedges with irq_out low until it is seen high.
    task automatic wait_rise(output int n, input int budget);
        n = 0;
        while (!irq_out && n < budget) begin
            @(negedge clk_100);
            n++;
        end
        if (!irq_out) check("wait_rise_expired", 32'(irq_out), 32'd1);
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        @(negedge clk_100);
        irq_ack = 1'b0;
    endtask

    task automatic pulse(input int idx);
        @(negedge clk_100);
        irq_src[idx] = 1'b1;
        @(negedge clk_100);
        irq_src[idx] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int exp_prio [3];
`ifdef TIMER_IRQ_RR_EN
        exp_prio = '{7, 12, 2};
`else
        exp_prio = '{2, 7, 12};
`endif
        #1;
        check("rst_irq_out", 32'(irq_out), 32'd0);
        check("rst_pend", 32'(pend_o), 32'd0);
        repeat (3) @(negedge clk_100);
        rst_100 = 1'b0;

        // single event on source 3
        pulse(3);
        wait_rise(n, 50);
        check("single_latency", 32'(n), 32'd2);
        check("single_vec", 32'(irq_vec), 32'd3);
        repeat (5) @(negedge clk_100);
        check("single_pend_held", 32'(pend_o[3]), 32'd1);
        do_ack();
        check("single_pend_clr", 32'(pend_o[3]), 32'd0);
        check("single_out_low", 32'(irq_out), 32'd0);
        check("single_miss", 32'(miss_cnt), 32'd0);

        // three simultaneous sources
        repeat (HOLD + 4) @(negedge clk_100);
        irq_src[2] = 1'b1; irq_src[7] = 1'b1; irq_src[12] = 1'b1;
        @(negedge clk_100);
        irq_src = '0;
        wait_rise(n, 50);
        check("prio_vec0", 32'(irq_vec), 32'(exp_prio[0]));
        for (int s = 1; s < 3; s++) begin
            do_ack();
            wait_rise(n, 50);
            check("prio_gap", 32'(n), 32'(HOLD + 2));
            check("prio_vec", 32'(irq_vec), 32'(exp_prio[s]));
        end
        do_ack();

        // masked source still latches
        repeat (HOLD + 4) @(negedge clk_100);
        irq_mask[5] = 1'b1;
        pulse(5);
        repeat (8) @(negedge clk_100);
        check("mask_pend", 32'(pend_o[5]), 32'd1);
        check("mask_out_low", 32'(irq_out), 32'd0);
        irq_mask[5] = 1'b0;
        wait_rise(n, 50);
        check("mask_latency", 32'(n), 32'd2);
        check("mask_vec", 32'(irq_vec), 32'd5);
        do_ack();

        // timeout without ack
        repeat (HOLD + 4) @(negedge clk_100);
        pulse(11);
        wait_rise(n, 50);
        n = 0;
        while (irq_out && n < 100) begin
            @(negedge clk_100);
            n++;
        end
        check("to_high_cycles", 32'(n), 32'(ACK_TO));
        check("to_flag", 32'(timeout_o), 32'd1);
        check("to_pend_clr", 32'(pend_o), 32'd0);
        repeat (HOLD + 4) @(negedge clk_100);
        pulse(1);
        wait_rise(n, 50);
        check("to_second_vec", 32'(irq_vec), 32'd1);
        do_ack();
        check("to_second_out", 32'(irq_out), 32'd0);
        check("to_flag_sticky", 32'(timeout_o), 32'd1);

        // lost events while pending and masked
        repeat (HOLD + 4) @(negedge clk_100);
        irq_mask[0] = 1'b1;
        repeat (4) pulse(0);
        check("lost_count", 32'(miss_cnt), 32'd3);
        check("lost_pend", 32'(pend_o[0]), 32'd1);
        irq_mask[0] = 1'b0;
        wait_rise(n, 50);
        check("lost_vec", 32'(irq_vec), 32'd0);
        irq_ack = 1'b1; irq_src[0] = 1'b1;
        @(negedge clk_100);
        irq_ack = 1'b0; irq_src[0] = 1'b0;
        check("ack_edge_pend", 32'(pend_o[0]), 32'd1);
        check("ack_edge_miss", 32'(miss_cnt), 32'd3);
        check("ack_edge_out", 32'(irq_out), 32'd0);
        wait_rise(n, 50);
        check("ack_edge_reserve", 32'(n), 32'(HOLD + 2));
        do_ack();

        // reset in the middle of a service
        repeat (HOLD + 4) @(negedge clk_100);
        irq_src[9] = 1'b1;
        @(negedge clk_100);
        wait_rise(n, 50);
        check("rst_pre_vec", 32'(irq_vec), 32'd9);
        #2 rst_100 = 1'b1;
        #1;
        check("rst_async_out", 32'(irq_out), 32'd0);
        check("rst_async_vec", 32'(irq_vec), 32'd0);
        check("rst_async_pend", 32'(pend_o), 32'd0);
        check("rst_async_miss", 32'(miss_cnt), 32'd0);
        check("rst_async_to", 32'(timeout_o), 32'd0);
        @(negedge clk_100);
        rst_100 = 1'b0;
        wait_rise(n, 50);
        check("rst_release_latency", 32'(n), 32'd3);
        check("rst_release_vec", 32'(irq_vec), 32'd9);
        do_ack();
        repeat (HOLD + 8) @(negedge clk_100);
        check("rst_served_once", 32'(irq_out), 32'd0);
        check("rst_pend_empty", 32'(pend_o), 32'd0);
        irq_src[9] = 1'b0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_100);
            if (c % 50 == 0) begin
                for (int i = 0; i < NUM_SRC; i++) irq_mask[i] = ($urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < NUM_SRC; i++) irq_src[i] = ($urandom_range(0, 11) == 0);
            irq_ack = irq_out ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 40) == 0);
        end
        @(negedge clk_100);
        irq_src = '0; irq_mask = '0; irq_ack = 1'b0;
        repeat (5) @(negedge clk_100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_irq_sched.md
# timer_irq_sched

Interrupt scheduler between the 15-bit periodic pulse bus from the timer-interrupt generator and the MicroBlaze single-line interrupt input. It latches rising edges from each source into a pending register and applies a per-source mask. It arbitrates among pending sources, presents one interrupt with a vector to the processor, and waits for an acknowledge, with a timeout. It also counts events lost because a source fired again while still pending.

## Interface
- NUM_SRC, 15, number of interrupt sources (1..16)
- VEC_W, 4, vector width; must satisfy 2^VEC_W >= NUM_SRC
- ACK_TIMEOUT, 32'd10000, cycles irq_out may stay high without irq_ack (10000 × 10 ns = 100 us); must be >= 1
- HOLDOFF, 32'd4, idle gap in cycles after each service, before the next arbitration; must be >= 1
- clk_100  in  1  100 MHz system clock
- rst_100  in  1  asynchronous, active-high reset
- irq_src  in  NUM_SRC  source pulses, synchronous to clk_100; each rising edge is one event
- irq_mask  in  NUM_SRC  1 = source blocked from arbitration; events are still latched as pending
- irq_ack  in  1  one-cycle acknowledge pulse from the processor
- irq_out  out  1  interrupt request to the MicroBlaze, level
- irq_vec  out  VEC_W  index of the source being serviced; valid while irq_out = 1
- pend_o  out  NUM_SRC  pending register, for software readback
- miss_cnt  out  16  count of events lost, saturating at 16'hFFFF
- timeout_o  out  1  sticky flag: at least one service timed out

## Operation
- Edge detect:
  - src_d is irq_src delayed by one register.
  - edge[i] = irq_src[i] & ~src_d[i].
  - An edge sets pend[i].
- Lost events: an edge on a source whose pend bit is already set, and is not being cleared that cycle, increments miss_cnt (saturating).
- FSM states:
  - IDLE: if (pend & ~irq_mask) != 0, go to ARB.
  - ARB: select the winner, register it into irq_vec, go to ASSERT.
  - ASSERT: irq_out = 1.
    - On irq_ack: clear pend[irq_vec], go to GAP.
    - Else, when the wait counter reaches ACK_TIMEOUT-1: clear pend[irq_vec], set timeout_o, go to GAP.
  - GAP: wait HOLDOFF cycles, then go to IDLE.
- Arbitration is fixed priority by default: the lowest index among pend & ~irq_mask wins.
- Simultaneous clear and edge on the same bit: the new edge wins. The bit stays set and miss_cnt is not incremented.
- irq_ack outside ASSERT is ignored.
- A mask change during ASSERT does not abort the current service.
- If the winner's pend bit is the only unmasked one and irq_mask changes during ARB, the service still proceeds.
- The wait counter is 32 bits and clears on entry to ASSERT. The GAP counter is 32 bits and clears on entry to GAP.
- Reset can occur mid-service. It returns every register and output to its reset value: irq_out = 0, irq_vec = 0, pend_o = 0, miss_cnt = 0, timeout_o = 0, src_d = 0, state = IDLE, all counters = 0.
- Sources already high when reset is released produce an edge on the first cycle out of reset, because src_d resets to 0.

## Timing
- All outputs are registered.
- Edge to irq_out, with the controller idle and the source unmasked:
  - The edge is sampled at clock edge t, and pend[i] is visible after edge t.
  - The FSM moves to ARB at t+1.
  - irq_out rises and irq_vec is valid after edge t+2.
- irq_ack sampled high at clock edge a:
  - irq_out falls and pend[irq_vec] clears after edge a.
  - The earliest next irq_out rise is after edge a + HOLDOFF + 2.
- Timeout: irq_out stays high exactly ACK_TIMEOUT cycles, then falls. timeout_o sets on the same edge.
- irq_vec holds its value through GAP and updates only in ARB.

## Configuration
- TIMER_IRQ_RR_EN defined: round-robin arbitration.
  - The search starts at (last_winner + 1) mod NUM_SRC, where last_winner is a register updated in ARB.
  - last_winner resets to NUM_SRC-1, so the first search starts at index 0.
- TIMER_IRQ_RR_EN undefined: fixed lowest-index priority. No last_winner register exists.

## Structure
- Package timer_irq_pkg holds:
  - FSM state encoding: IDLE, ARB, ASSERT, GAP.
  - MISS_CNT_W = 16.
  - Default ACK_TIMEOUT and HOLDOFF constants.
- One sub-module, timer_irq_arb: purely combinational priority/round-robin picker.
  - Inputs: request vector and start index.
  - Outputs: grant index and grant-valid.
- The FSM, counters and pending logic stay in timer_irq_sched.

## Test plan
- Single event: pulse irq_src[3] for 1 cycle, ack 5 cycles after irq_out rises.
  - irq_out rises 2 cycles after sampling, irq_vec = 3.
  - pend_o[3] clears on the ack edge; miss_cnt = 0.
- Priority: raise sources 2, 7 and 12 in the same cycle, ack each service.
  - Fixed priority: served 2, 7, 12, with a HOLDOFF + 2 gap between irq_out pulses.
  - With TIMER_IRQ_RR_EN after last_winner = 7: served 12, 2.
- Mask: event on source 5 with irq_mask[5] = 1.
  - pend_o[5] = 1 and irq_out stays 0.
  - Clearing the mask gives irq_out = 1 with vec = 5 two cycles later.
- Timeout: ACK_TIMEOUT = 20, no ack.
  - irq_out is high for exactly 20 cycles.
  - timeout_o = 1 and pend_o clears.
  - A second event is serviced normally; timeout_o stays 1.
- Lost events: three edges on source 0 while it is pending and masked → miss_cnt = 3. An edge coinciding with its ack cycle → pend stays 1, miss_cnt unchanged.
- Reset mid-ASSERT: assert rst_100 for 1 cycle.
  - All outputs go to 0 immediately, asynchronously.
  - A source held high through the reset release is serviced once afterwards.
